imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/y86_pkg.sv | 20 ++
 rtl/imem_array.sv | 34 +++
 rtl/imem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Definitions shared between the instruction-memory responder and the fetch stage.
// Covers the FSM state encoding, the instruction window width and the processor status codes.
package y86_pkg;

    localparam int INSTR_BYTES = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_e;

endpackage

// File: rtl/imem_array.sv
// Byte-wide instruction store with one synchronous write port and a combinational
// INSTR_BYTES-wide little-endian read window.
module imem_array
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [8*INSTR_BYTES-1:0] rd_data
);

    // Contents are deliberately not reset; the program is loaded through the write port.
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The index wraps in AW bits; the responder never uses a wrapped window.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < INSTR_BYTES; i++) begin
            rd_data[8*i +: 8] = mem_q[rd_addr + AW'(i)];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one PC at a time and returns a 10-byte window
// LATENCY cycles later. Out-of-range windows are flagged with rsp_error and zero data.
module imem_responder
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    input  logic [63:0]              req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [8*INSTR_BYTES-1:0] rsp_data,
    output logic                     rsp_error,
    input  logic                     rsp_ready,
    input  logic                     ld_en,
    input  logic [AW-1:0]            ld_addr,
    input  logic [7:0]               ld_data
);

    localparam logic [63:0] LAST_START = 64'(MEM_BYTES - INSTR_BYTES);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    imem_state_e              state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     err_q, err_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [8*INSTR_BYTES-1:0] rsp_data_q, rsp_data_d;
    logic                     rsp_error_q, rsp_error_d;

    logic [8*INSTR_BYTES-1:0] rd_data;
    logic                     accept_err;

    imem_array #(
        .MEM_BYTES(MEM_BYTES)
    ) u_array (
        .clock  (clock),
        .wr_en  (ld_en),
        .wr_addr(ld_addr),
        .wr_data(ld_data),
        .rd_addr(addr_q),
        .rd_data(rd_data)
    );

    // High bits set, or a window running past the last byte; no wrap-around allowed.
    assign accept_err = ((req_addr >> AW) != 64'd0) || (req_addr > LAST_START);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr[AW-1:0];
                    err_d       = accept_err;
                    cnt_d       = CNT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Memory is sampled on the RESP-entry edge, so a same-edge load is not seen.
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = err_q;
                    rsp_data_d  = err_q ? '0 : rd_data;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;

endmodule
